block_dispatch: RTL
===================

// Module: block_dispatch
// PURPOSE
//   Grid-level scheduler sitting above the per-CU wave_dispatch units. On a kernel
//   launch it computes the block count from num_threads/block_dim and hands block ids
//   to idle compute units. It tracks per-CU block completion, recycles each CU for the
//   next block, and flags kernel completion once every block has retired.
// PARAMETERS
//   NUM_CUS  2   number of compute units served (each has one wave_dispatch)
// PORTS
//   clk            in   1            clock
//   rst            in   1            synchronous, active-high reset
//   start          in   1            kernel launch pulse; honoured only in IDLE or DONE
//   num_threads    in   32           total kernel threads, sampled on accepted start
//   block_dim      in   32           threads per block, sampled on accepted start
//   cu_block_done  in   NUM_CUS      per-CU block-finished level (wave_dispatch block_done)
//   cu_start       out  NUM_CUS      per-CU enable, high while CU owns a block
//   cu_rst         out  NUM_CUS      per-CU 1-cycle clear pulse issued with each assignment
//   cu_block_id    out  32*NUM_CUS   signed block id per CU, CU i at [32*i+:32]; -1 = none
//   num_blocks     out  32           registered ceil(num_threads/block_dim)
//   busy           out  1            high in CALC and DISPATCH
//   kernel_done    out  1            high in DONE, held until next accepted start or rst
// BEHAVIOUR
//   Reset: state=IDLE; cu_start=0, cu_rst=0, all cu_block_id=-1, num_blocks=0, busy=0,
//     kernel_done=0, internal blocks_issued=blocks_done=0. Reset mid-kernel drops all work.
//   FSM: IDLE -start-> CALC -> DISPATCH -(blocks_done==num_blocks)-> DONE -start-> CALC.
//   CALC (1 cycle): latch inputs; num_blocks <= (block_dim==0) ? 0 :
//     (num_threads + block_dim - 1) / block_dim, computed at 33 bits (no overflow);
//     clear blocks_issued, blocks_done, and all cu_start/cu_block_id.
//   DISPATCH: goes directly to DONE when num_blocks==0.
//   Timing: start is sampled at edge E0, num_blocks registers at E1, first assignment at E2.
//   Assignment: at most one per cycle. Pick the lowest-index i with cu_start[i]==0 whose
//     cu_block_done[i] is not being consumed this cycle. Only if blocks_issued<num_blocks:
//     cu_block_id[i]<=blocks_issued, cu_start[i]<=1, cu_rst[i]<=1 (for 1 cycle),
//     blocks_issued++. Block ids are 0-based, 0..num_blocks-1.
//   Completion: cu_block_done[i] && cu_start[i] && !cu_rst[i] ->
//     cu_start[i]<=0, cu_block_id[i]<=-1, blocks_done++.
//     Multiple CUs may complete in the same cycle; blocks_done adds the popcount.
//     cu_block_done is ignored while cu_start[i]==0 or in the cycle cu_rst[i] is high,
//     because the CU's done flag is stale.
//   A CU freed at edge N is eligible for reassignment at edge N+1 (1 idle cycle min).
//   DONE is entered on the edge where blocks_done reaches num_blocks. In DONE, all
//     cu_start=0 and kernel_done=1. start in DONE re-enters CALC and clears kernel_done.
//   start is ignored in CALC and DISPATCH; num_threads and block_dim are not re-sampled there.
//   Counters are 32-bit unsigned; num_blocks <= 2^32-1 by construction.
// TESTING
//   1. rst held 2 cycles -> all outputs at reset values, every cu_block_id == -1.
//   2. num_threads=128, block_dim=64, start -> num_blocks=2; E2: CU0 id0 with cu_rst[0]
//      pulse; E3: CU1 id1. Pulse both dones -> DONE, kernel_done=1 the next edge.
//   3. num_threads=200, block_dim=64 -> num_blocks=4. Complete CU0 first -> CU0 gets id2 one
//      cycle after free, then id3 goes to the first CU freed after that; kernel_done only
//      after 4 completions.
//   4. Both CUs assert done on the same edge with 2 blocks left -> blocks_done += 2; CU0
//      reassigned the next edge, CU1 on the edge after (one assignment per cycle).
//   5. block_dim=0 or num_threads=0 -> num_blocks=0, DONE at E2, no cu_start activity.
//   6. start during DISPATCH ignored; rst mid-DISPATCH -> IDLE, cu_start=0, ids=-1;
//      a new start then runs cleanly.

Source files
------------

// File: rtl/block_dispatch_if.sv
// block_dispatch_if: kernel-launch and per-CU control bundle for block_dispatch.
//   master (launcher / CU side): drives start, num_threads, block_dim, cu_block_done.
//   slave  (block_dispatch):     drives cu_start, cu_rst, cu_block_id, num_blocks,
//                                busy, kernel_done.
//   cu_block_id[i] is the signed block id owned by CU i (-1 = none); packed so CU i
//   sits at bits [32*i+:32] of the flattened vector.
interface block_dispatch_if #(
  parameter int NUM_CUS = 2
);
  logic                     start;
  logic [31:0]              num_threads;
  logic [31:0]              block_dim;
  logic [NUM_CUS-1:0]       cu_block_done;
  logic [NUM_CUS-1:0]       cu_start;
  logic [NUM_CUS-1:0]       cu_rst;
  logic [NUM_CUS-1:0][31:0] cu_block_id;
  logic [31:0]              num_blocks;
  logic                     busy;
  logic                     kernel_done;

  modport master (
    output start, num_threads, block_dim, cu_block_done,
    input  cu_start, cu_rst, cu_block_id, num_blocks, busy, kernel_done
  );

  modport slave (
    input  start, num_threads, block_dim, cu_block_done,
    output cu_start, cu_rst, cu_block_id, num_blocks, busy, kernel_done
  );
endinterface

// File: rtl/block_dispatch.sv
// block_dispatch: grid-level scheduler above the per-CU wave_dispatch units.
//   On an accepted start it latches num_threads/block_dim, computes
//   num_blocks = ceil(num_threads/block_dim), then hands block ids 0..num_blocks-1
//   to idle CUs (one assignment per cycle, lowest free CU first), recycles CUs as
//   they report block_done, and raises kernel_done once every block has retired.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       block_dispatch_if.slave (launch inputs, per-CU control/status)

// Per-CU ownership slot: holds start/rst/id for one compute unit.
module block_dispatch_cu (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,       // drop ownership (CALC / DONE)
  input  logic        asg,       // assign id_in to this CU this cycle
  input  logic [31:0] id_in,
  input  logic        done_in,   // CU block_done level
  output logic        cu_start,
  output logic        cu_rst,
  output logic [31:0] cu_block_id,
  output logic        consume    // completion accepted this cycle
);
  // The CU's done flag is stale until it has been cleared by cu_rst and is
  // actually working on a block, so only trust it after the clear cycle.
  assign consume = done_in & cu_start & ~cu_rst;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cu_start    <= 1'b0;
      cu_rst      <= 1'b0;
      cu_block_id <= '1;
    end else begin
      cu_rst <= asg;
      if (asg) begin
        cu_start    <= 1'b1;
        cu_block_id <= id_in;
      end else if (consume) begin
        cu_start    <= 1'b0;
        cu_block_id <= '1;
      end
    end
  end
endmodule

module block_dispatch #(
  parameter int NUM_CUS = 2
) (
  input  logic           clk,
  input  logic           rst,
  block_dispatch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DISPATCH, DONE} state_t;

  state_t                   state;
  logic [31:0]              nt_q, bd_q;
  logic [31:0]              num_blocks;
  logic [31:0]              blocks_issued, blocks_done;
  logic                     busy, kernel_done;

  logic [NUM_CUS-1:0]       cu_start, cu_rst, consume, grant, asg;
  logic [NUM_CUS-1:0][31:0] cu_id;
  logic [32:0]              nb_wide;
  logic [31:0]              done_inc, done_next;
  logic                     issue_ok, clr_all;

  // 33-bit ceil-divide so num_threads + block_dim - 1 cannot wrap.
  always_comb begin
    nb_wide = '0;
    if (bd_q != 32'd0)
      nb_wide = ({1'b0, nt_q} + {1'b0, bd_q} - 33'd1) / {1'b0, bd_q};
  end

  // Lowest-index CU not owning a block. A CU completing this cycle still has
  // cu_start=1, so it is naturally excluded and becomes eligible next cycle.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_CUS; i++)
      if (!cu_start[i] && grant == '0) grant[i] = 1'b1;
  end

  always_comb begin
    done_inc = '0;
    for (int i = 0; i < NUM_CUS; i++) done_inc = done_inc + 32'(consume[i]);
  end

  assign done_next = blocks_done + done_inc;
  assign issue_ok  = (state == DISPATCH) && (blocks_issued < num_blocks);
  assign asg       = issue_ok ? grant : '0;
  assign clr_all   = (state == CALC) || (state == DONE);

  for (genvar i = 0; i < NUM_CUS; i++) begin : g_cu
    block_dispatch_cu u_cu (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr_all),
      .asg         (asg[i]),
      .id_in       (blocks_issued),
      .done_in     (bus.cu_block_done[i]),
      .cu_start    (cu_start[i]),
      .cu_rst      (cu_rst[i]),
      .cu_block_id (cu_id[i]),
      .consume     (consume[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      nt_q          <= '0;
      bd_q          <= '0;
      num_blocks    <= '0;
      blocks_issued <= '0;
      blocks_done   <= '0;
      busy          <= 1'b0;
      kernel_done   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            nt_q        <= bus.num_threads;
            bd_q        <= bus.block_dim;
            state       <= CALC;
            busy        <= 1'b1;
            kernel_done <= 1'b0;
          end
        end
        CALC: begin
          num_blocks    <= nb_wide[31:0];
          blocks_issued <= '0;
          blocks_done   <= '0;
          state         <= DISPATCH;
        end
        DISPATCH: begin
          if (num_blocks == 32'd0) begin
            state       <= DONE;
            busy        <= 1'b0;
            kernel_done <= 1'b1;
          end else begin
            if (asg != '0) blocks_issued <= blocks_issued + 32'd1;
            blocks_done <= done_next;
            if (done_next == num_blocks) begin
              state       <= DONE;
              busy        <= 1'b0;
              kernel_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cu_start    = cu_start;
  assign bus.cu_rst      = cu_rst;
  assign bus.cu_block_id = cu_id;
  assign bus.num_blocks  = num_blocks;
  assign bus.busy        = busy;
  assign bus.kernel_done = kernel_done;
endmodule
